lu_sweep_ctrl: RTL
==================

Name: lu_sweep_ctrl

Overview:
- Sequential sweep controller that sits directly upstream of the 8-function logic unit (gate bank + 3-bit select mux) and drives its operand and select inputs.
- On a start request it walks all 8 select codes and, for each code, all 4 operand pairs (x,y).
- After each step's operands have settled it samples the unit's output s and builds a 32-bit truth-table word.
- Used for bring-up and regression of the logic unit without a hand-written stimulus list.

Parameters:
- SETTLE_CYC, 1, cycles the operands/select are held before s_in is sampled; legal range 1..15.

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request a sweep; sampled only in IDLE
- s_in  input  1  result s from the logic unit (combinational path)
- x  output  1  operand x to the logic unit
- y  output  1  operand y to the logic unit
- c1  output  1  select bit 2 (MSB of op index)
- c2  output  1  select bit 1
- c3  output  1  select bit 0
- busy  output  1  high while a sweep is in progress
- done  output  1  one-cycle pulse when the sweep completes
- table_out  output  32  captured truth table, bit [4k + 2x + y] = s for op k, operands (x,y)
- pass  output  1  present only with LU_SELFCHECK_EN

Behaviour:
- Clock and reset: one clock domain; reset is asynchronous and active-low.
- Reset values: state=IDLE, idx=0, settle counter=0; x, y, c1, c2, c3 = 0; busy=0, done=0, table_out=0, pass=0.
- Step index: idx[4:0] is a register.
  - {c1,c2,c3} = idx[4:2]; x = idx[1]; y = idx[0].
  - All are driven straight from registers, with no combinational path from start.
- FSM states and transitions:
  - IDLE: busy=0. If start=1 → SETTLE with idx=0 and counter=0.
  - SETTLE: busy=1. Counter increments each cycle. When counter == SETTLE_CYC-1 → SAMPLE.
  - SAMPLE: busy=1. table_out[idx] <= s_in; all other bits are unchanged.
    - If idx == 31 → DONE.
    - Otherwise idx <= idx+1, counter <= 0, → SETTLE.
  - DONE: busy=0, done=1 for exactly one cycle; idx <= 0 → IDLE.
- Latency: busy is high for exactly 32*(SETTLE_CYC+1) cycles. done asserts on the cycle after the last SAMPLE.
- table_out:
  - Cleared to 0 on the cycle start is accepted.
  - Holds its value from DONE until the next accepted start.
- start while busy or in DONE: ignored; no queuing.
- start held high continuously: a new sweep begins on the IDLE cycle that follows DONE (back-to-back).
- Reset mid-sweep: immediate return to reset values; the partial table is discarded.
- Op order by idx[4:2] (c1c2c3) and the nibble each op produces:
  - 000 NOTx, expected nibble 0x3
  - 001 XNOR, 0x9
  - 010 NAND, 0x7
  - 011 NOR, 0x1
  - 100 AND, 0x8
  - 101 OR, 0xE
  - 110 XOR, 0x6
  - 111 NOTy, 0x5
- Golden table for a correct logic unit: 0x56E81793.

Optional Feature:
- Macro: LU_SELFCHECK_EN
- Defined:
  - The pass output exists.
  - In DONE, pass <= (table_out with the final sample merged == LU_GOLDEN).
  - pass holds until the next accepted start, where it clears to 0.
- Undefined: no pass port, no comparator logic.

Decomposition:
- Package lu_pkg:
  - state enum {IDLE, SETTLE, SAMPLE, DONE}
  - localparam LU_GOLDEN = 32'h56E81793
  - op-code constants OP_NOTX..OP_NOTY (3-bit)
  - per-op expected nibbles
- Sub-module lu_settle_timer (4-bit down/up counter with load and expire flag) is natural; the FSM and capture register stay in the top module.

Test Plan:
- Reset then idle: rst_n low for 3 cycles, start=0 → all outputs 0; busy stays 0 for 20 cycles.
- Full sweep with SETTLE_CYC=1, bench models the logic unit correctly:
  - start pulse → busy high for 64 cycles, done pulse once, table_out = 0x56E81793.
  - pass=1 when LU_SELFCHECK_EN is defined.
- Faulty unit (bench forces s_in=0 for op 101) → table_out = 0x5608 1793 with the OR nibble cleared, i.e. 0x56081793; pass=0.
- start re-pulsed at cycle 10 of a sweep → ignored; done occurs at the original time with a correct table.
- Reset mid-sweep: rst_n low at cycle 30 → outputs return to reset values that cycle. A new start then completes normally with 0x56E81793.
- SETTLE_CYC=4, start held high → busy for 160 cycles, done pulse, one IDLE cycle, then the second sweep starts. Sampling occurs only on the 5th cycle of each step.

Source files
------------

// File: rtl/lu_pkg.sv
// -----------------------------------------------------------------------------
// lu_pkg
// Shared definitions for the logic-unit sweep controller.
//   - lu_state_e : sweep FSM states
//   - LU_GOLDEN  : truth-table word produced by a correct 8-function logic unit
//   - OP_*       : 3-bit select codes ({c1,c2,c3}) in sweep order
//   - NIB_*      : 4-bit truth-table nibble each op produces,
//                  bit [2x+y] = s for operands (x,y)
// No ports (package).
// -----------------------------------------------------------------------------
package lu_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } lu_state_e;

  localparam logic [31:0] LU_GOLDEN = 32'h56E8_1793;

  localparam logic [2:0] OP_NOTX = 3'd0;
  localparam logic [2:0] OP_XNOR = 3'd1;
  localparam logic [2:0] OP_NAND = 3'd2;
  localparam logic [2:0] OP_NOR  = 3'd3;
  localparam logic [2:0] OP_AND  = 3'd4;
  localparam logic [2:0] OP_OR   = 3'd5;
  localparam logic [2:0] OP_XOR  = 3'd6;
  localparam logic [2:0] OP_NOTY = 3'd7;

  localparam logic [3:0] NIB_NOTX = 4'h3;
  localparam logic [3:0] NIB_XNOR = 4'h9;
  localparam logic [3:0] NIB_NAND = 4'h7;
  localparam logic [3:0] NIB_NOR  = 4'h1;
  localparam logic [3:0] NIB_AND  = 4'h8;
  localparam logic [3:0] NIB_OR   = 4'hE;
  localparam logic [3:0] NIB_XOR  = 4'h6;
  localparam logic [3:0] NIB_NOTY = 4'h5;

  // Expected nibble for a select code; concatenating these for ops 7..0
  // reproduces LU_GOLDEN.
  function automatic logic [3:0] lu_exp_nibble(input logic [2:0] op);
    logic [3:0] nib;
    case (op)
      OP_NOTX: nib = NIB_NOTX;
      OP_XNOR: nib = NIB_XNOR;
      OP_NAND: nib = NIB_NAND;
      OP_NOR:  nib = NIB_NOR;
      OP_AND:  nib = NIB_AND;
      OP_OR:   nib = NIB_OR;
      OP_XOR:  nib = NIB_XOR;
      default: nib = NIB_NOTY;
    endcase
    return nib;
  endfunction

endpackage

// File: rtl/lu_settle_timer.sv
// -----------------------------------------------------------------------------
// lu_settle_timer
// 4-bit up counter that measures how long the operands have been held.
// Ports:
//   clk      - clock, rising edge
//   rst_n    - asynchronous active-low reset (count -> 0)
//   clr_i    - synchronous clear to 0 (has priority over en_i)
//   en_i     - count up by one
//   expire_o - high while the count equals SETTLE_CYC-1
// Parameter SETTLE_CYC: hold time in cycles, legal range 1..15.
// -----------------------------------------------------------------------------
module lu_settle_timer #(
  parameter int unsigned SETTLE_CYC = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam logic [3:0] LAST = 4'(SETTLE_CYC - 1);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = 4'd0;
    end else if (en_i) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = (cnt_q == LAST);

endmodule

// File: rtl/lu_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// lu_sweep_ctrl
// Sweeps the 8-function logic unit through every select code and operand
// pair, holding each step for SETTLE_CYC cycles and then sampling the unit's
// result into a 32-bit truth-table word.
// Ports:
//   clk       - clock, rising edge
//   rst_n     - asynchronous active-low reset
//   start     - sweep request, only honoured in IDLE
//   s_in      - result from the logic unit
//   x, y      - operands = idx[1], idx[0]
//   c1,c2,c3  - select = idx[4:2]
//   busy      - high in SETTLE and SAMPLE
//   done      - one-cycle pulse in DONE
//   table_out - bit [4k+2x+y] = s for op k, operands (x,y)
//   pass      - (only with LU_SELFCHECK_EN) table matched LU_GOLDEN
// Optional feature macro: LU_SELFCHECK_EN adds the pass port and comparator.
// Parameter SETTLE_CYC: legal range 1..15.
// Handshake: start is a level request, no ready; a request seen outside IDLE
// is dropped, and a level held through DONE starts the next sweep on the
// IDLE cycle that follows.
// -----------------------------------------------------------------------------
module lu_sweep_ctrl
  import lu_pkg::*;
#(
  parameter int unsigned SETTLE_CYC = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        s_in,
  output logic        x,
  output logic        y,
  output logic        c1,
  output logic        c2,
  output logic        c3,
  output logic        busy,
  output logic        done,
  output logic [31:0] table_out
`ifdef LU_SELFCHECK_EN
  ,
  output logic        pass
`endif
);

  lu_state_e   state_q, state_d;
  logic [4:0]  idx_q, idx_d;
  logic [31:0] table_q, table_d;
  logic        settle_exp;

  lu_settle_timer #(
    .SETTLE_CYC(SETTLE_CYC)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (state_q != SETTLE),
    .en_i     (state_q == SETTLE),
    .expire_o (settle_exp)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SETTLE;
      SETTLE:  if (settle_exp) state_d = SAMPLE;
      SAMPLE:  state_d = (idx_q == 5'd31) ? DONE : SETTLE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic (Moore)
  always_comb begin
    busy = (state_q == SETTLE) || (state_q == SAMPLE);
    done = (state_q == DONE);
  end

  // Step index and capture register
`ifdef LU_SELFCHECK_EN
  logic pass_q, pass_d;
`endif

  always_comb begin
    idx_d   = idx_q;
    table_d = table_q;
`ifdef LU_SELFCHECK_EN
    pass_d  = pass_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          idx_d   = 5'd0;
          table_d = 32'd0;
`ifdef LU_SELFCHECK_EN
          pass_d  = 1'b0;
`endif
        end
      end
      SAMPLE: begin
        table_d[idx_q] = s_in;
        if (idx_q != 5'd31) idx_d = idx_q + 5'd1;
      end
      DONE: begin
        idx_d  = 5'd0;
        // The last sample was written on the SAMPLE->DONE edge, so
        // table_q already holds the complete word here.
`ifdef LU_SELFCHECK_EN
        pass_d = (table_q == LU_GOLDEN);
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q   <= 5'd0;
      table_q <= 32'd0;
    end else begin
      idx_q   <= idx_d;
      table_q <= table_d;
    end
  end

`ifdef LU_SELFCHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pass_q <= 1'b0;
    end else begin
      pass_q <= pass_d;
    end
  end
  assign pass = pass_q;
`endif

  // Operands and select come straight from the index register.
  assign {c1, c2, c3} = idx_q[4:2];
  assign x            = idx_q[1];
  assign y            = idx_q[0];
  assign table_out    = table_q;

endmodule
